// File: rtl/painterengine_gpu_writer_scheduler.sv
// ----------------------------------------------------------------------------
// painterengine_gpu_writer_scheduler
//
// Shares one DMA writer between four requesting channels. An idle scheduler
// picks a channel round-robin, holds the writer in reset with the router
// stable for PARAM_RELEASE_CYCLES, then releases it and waits for done, error
// or a timeout. The result is reported on the granted channel's done/error
// flag and held until that channel drops its request (four-phase handshake).
//
// Ports:
//   i_wire_clock              clock, all state on the rising edge
//   i_wire_resetn             asynchronous active-low reset
//   i_wire_request[3:0]       per-channel job request level
//   o_wire_grant[3:0]         one-hot granted channel, or 0
//   o_wire_channel_done[3:0]  per-channel success flag
//   o_wire_channel_error[3:0] per-channel failure flag
//   o_wire_error_type[2:0]    result code of the last finished job
//   o_wire_busy               high whenever the scheduler is not idle
//   o_wire_writer_router[3:0] one-hot channel select to the writer
//   o_wire_writer_resetn      active-low reset to the writer
//   i_wire_writer_done        writer job complete
//   i_wire_writer_error       writer in an error state
//   i_wire_writer_error_type  writer error code
// ----------------------------------------------------------------------------
module painterengine_gpu_writer_scheduler #(
    parameter int PARAM_RELEASE_CYCLES = 2,
    parameter int PARAM_TIMEOUT_CYCLES = 65535
) (
    input  logic       i_wire_clock,
    input  logic       i_wire_resetn,
    input  logic [3:0] i_wire_request,
    output logic [3:0] o_wire_grant,
    output logic [3:0] o_wire_channel_done,
    output logic [3:0] o_wire_channel_error,
    output logic [2:0] o_wire_error_type,
    output logic       o_wire_busy,
    output logic [3:0] o_wire_writer_router,
    output logic       o_wire_writer_resetn,
    input  logic       i_wire_writer_done,
    input  logic       i_wire_writer_error,
    input  logic [2:0] i_wire_writer_error_type
);

    localparam logic [3:0]  RELEASE_LAST  = 4'(PARAM_RELEASE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(PARAM_TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_COMPLETE
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  last_grant_reg, last_grant_next;
    logic [3:0]  release_cnt_reg, release_cnt_next;
    logic [15:0] run_cnt_reg, run_cnt_next;
    logic [3:0]  grant_reg, grant_next;
    logic [3:0]  done_reg, done_next;
    logic [3:0]  error_reg, error_next;
    logic [2:0]  error_type_reg, error_type_next;
    logic        busy_reg, busy_next;
    logic        writer_resetn_reg, writer_resetn_next;

    // Round-robin candidates: slot gi holds channel (last_grant + 1 + gi) mod 4,
    // so slot 0 is the highest-priority channel and slot 3 is last_grant itself.
    logic [1:0] rr_idx [4];
    logic [3:0] rr_hit;
    logic       rr_any;
    logic [1:0] rr_pick;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rr
        assign rr_idx[gi] = last_grant_reg + 2'(gi + 1);
        assign rr_hit[gi] = i_wire_request[rr_idx[gi]];
    end

    // Lowest slot wins: scan downward so the last hit written is the winner.
    always_comb begin
        rr_any  = 1'b0;
        rr_pick = last_grant_reg;
        for (int k = 3; k >= 0; k--) begin
            if (rr_hit[k]) begin
                rr_any  = 1'b1;
                rr_pick = rr_idx[k];
            end
        end
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_reg         <= ST_IDLE;
            last_grant_reg    <= 2'd3;
            release_cnt_reg   <= 4'd0;
            run_cnt_reg       <= 16'd0;
            grant_reg         <= 4'd0;
            done_reg          <= 4'd0;
            error_reg         <= 4'd0;
            error_type_reg    <= 3'd0;
            busy_reg          <= 1'b0;
            writer_resetn_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            last_grant_reg    <= last_grant_next;
            release_cnt_reg   <= release_cnt_next;
            run_cnt_reg       <= run_cnt_next;
            grant_reg         <= grant_next;
            done_reg          <= done_next;
            error_reg         <= error_next;
            error_type_reg    <= error_type_next;
            busy_reg          <= busy_next;
            writer_resetn_reg <= writer_resetn_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        last_grant_next    = last_grant_reg;
        release_cnt_next   = release_cnt_reg;
        run_cnt_next       = run_cnt_reg;
        grant_next         = grant_reg;
        done_next          = done_reg;
        error_next         = error_reg;
        error_type_next    = error_type_reg;
        busy_next          = busy_reg;
        writer_resetn_next = writer_resetn_reg;

        case (state_reg)
            ST_IDLE: begin
                if (rr_any) begin
                    grant_next       = 4'b0001 << rr_pick;
                    last_grant_next  = rr_pick;
                    release_cnt_next = 4'd0;
                    busy_next        = 1'b1;
                    state_next       = ST_LAUNCH;
                end
            end

            // Writer stays in reset while the router settles; writer status
            // lines are meaningless here and are not looked at.
            ST_LAUNCH: begin
                if (release_cnt_reg == RELEASE_LAST) begin
                    release_cnt_next   = 4'd0;
                    run_cnt_next       = 16'd0;
                    writer_resetn_next = 1'b1;
                    state_next         = ST_RUN;
                end else begin
                    release_cnt_next = release_cnt_reg + 4'd1;
                end
            end

            // Error takes precedence over done; timeout only when both are low.
            ST_RUN: begin
                if (i_wire_writer_error) begin
                    error_next         = grant_reg;
                    error_type_next    = i_wire_writer_error_type;
                    writer_resetn_next = 1'b0;
                    state_next         = ST_COMPLETE;
                end else if (i_wire_writer_done) begin
                    done_next          = grant_reg;
                    error_type_next    = 3'b000;
                    writer_resetn_next = 1'b0;
                    state_next         = ST_COMPLETE;
                end else if (run_cnt_reg == TIMEOUT_LIMIT) begin
                    error_next         = grant_reg;
                    error_type_next    = 3'b111;
                    writer_resetn_next = 1'b0;
                    state_next         = ST_COMPLETE;
                end else begin
                    run_cnt_next = run_cnt_reg + 16'd1;
                end
            end

            // Result is held until the owning channel withdraws its request.
            ST_COMPLETE: begin
                if ((i_wire_request & grant_reg) == 4'd0) begin
                    grant_next   = 4'd0;
                    done_next    = 4'd0;
                    error_next   = 4'd0;
                    run_cnt_next = 16'd0;
                    busy_next    = 1'b0;
                    state_next   = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_wire_grant         = grant_reg;
    assign o_wire_writer_router = grant_reg;
    assign o_wire_channel_done  = done_reg;
    assign o_wire_channel_error = error_reg;
    assign o_wire_error_type    = error_type_reg;
    assign o_wire_busy          = busy_reg;
    assign o_wire_writer_resetn = writer_resetn_reg;

endmodule

// File: tb/tb_painterengine_gpu_writer_scheduler.sv
module tb_painterengine_gpu_writer_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] request;
    logic [3:0] grant;
    logic [3:0] ch_done;
    logic [3:0] ch_err;
    logic [2:0] err_type;
    logic       busy;
    logic [3:0] router;
    logic       wr_resetn;
    logic       wr_done;
    logic       wr_error;
    logic [2:0] wr_type;

    painterengine_gpu_writer_scheduler #(
        .PARAM_RELEASE_CYCLES(2),
        .PARAM_TIMEOUT_CYCLES(16)
    ) dut (
        .i_wire_clock             (clk),
        .i_wire_resetn            (rst_n),
        .i_wire_request           (request),
        .o_wire_grant             (grant),
        .o_wire_channel_done      (ch_done),
        .o_wire_channel_error     (ch_err),
        .o_wire_error_type        (err_type),
        .o_wire_busy              (busy),
        .o_wire_writer_router     (router),
        .o_wire_writer_resetn     (wr_resetn),
        .i_wire_writer_done       (wr_done),
        .i_wire_writer_error      (wr_error),
        .i_wire_writer_error_type (wr_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] req;
        int         kind;      // 0 done, 1 error, 2 done+error, 3 timeout
        logic [2:0] wtype;
        int         delay;     // RUN cycles before the writer responds
        logic [3:0] exp_grant;
        logic [3:0] exp_done;
        logic [3:0] exp_err;
        logic [2:0] exp_type;
    } vec_t;

    typedef struct {
        logic [3:0] grant;
        logic [3:0] done;
        logic [3:0] err;
        logic [2:0] etype;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected result and compare it with the finished job.
    task automatic compare_sb(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, " sb_nonempty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check({tag, " grant"}, grant, e.grant);
            check({tag, " done"}, ch_done, e.done);
            check({tag, " error"}, ch_err, e.err);
            check({tag, " error_type"}, err_type, e.etype);
            check({tag, " writer_resetn"}, wr_resetn, 0);
        end
    endtask

    task automatic wait_grant(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (grant != 4'd0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        vec_t v;
        exp_t e;
        logic ok;
        int   lcnt;
        int   rcnt;
        int   exp_len;

        rst_n    = 1'b0;
        request  = 4'd0;
        wr_done  = 1'b0;
        wr_error = 1'b0;
        wr_type  = 3'd0;

        // ---- reset state ----
        #13;
        check("reset grant", grant, 0);
        check("reset router", router, 0);
        check("reset done", ch_done, 0);
        check("reset error", ch_err, 0);
        check("reset error_type", err_type, 0);
        check("reset busy", busy, 0);
        check("reset writer_resetn", wr_resetn, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- single request on channel 2, cycle-exact ----
        request = 4'b0100;
        tick();
        check("single grant N+1", grant, 4'b0100);
        check("single router N+1", router, 4'b0100);
        check("single busy N+1", busy, 1);
        check("single writer_resetn N+1", wr_resetn, 0);
        tick();
        check("single writer_resetn N+2", wr_resetn, 0);
        check("single router N+2", router, 4'b0100);
        tick();
        check("single writer_resetn N+3", wr_resetn, 1);
        tick();
        tick();
        e = '{4'b0100, 4'b0100, 4'b0000, 3'b000};
        sb_q.push_back(e);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        compare_sb("single");
        tick();
        check("single hold done", ch_done, 4'b0100);
        check("single hold grant", grant, 4'b0100);
        request = 4'b0000;
        tick();
        check("single clear grant", grant, 0);
        check("single clear router", router, 0);
        check("single clear done", ch_done, 0);
        check("single clear busy", busy, 0);

        // Reset so the table starts from last_grant = 3.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // ---- table: round-robin order, errors, timeout ----
        vecs[0] = '{4'b1111, 0, 3'b000, 3, 4'b0001, 4'b0001, 4'b0000, 3'b000};
        vecs[1] = '{4'b1111, 1, 3'b011, 2, 4'b0010, 4'b0000, 4'b0010, 3'b011};
        vecs[2] = '{4'b1111, 2, 3'b101, 0, 4'b0100, 4'b0000, 4'b0100, 3'b101};
        vecs[3] = '{4'b1111, 3, 3'b000, 0, 4'b1000, 4'b0000, 4'b1000, 3'b111};
        vecs[4] = '{4'b1111, 0, 3'b000, 5, 4'b0001, 4'b0001, 4'b0000, 3'b000};
        vecs[5] = '{4'b1010, 0, 3'b000, 1, 4'b0010, 4'b0010, 4'b0000, 3'b000};
        vecs[6] = '{4'b1001, 1, 3'b010, 4, 4'b1000, 4'b0000, 4'b1000, 3'b010};
        vecs[7] = '{4'b0110, 0, 3'b000, 2, 4'b0010, 4'b0010, 4'b0000, 3'b000};
        vecs[8] = '{4'b0100, 0, 3'b000, 0, 4'b0100, 4'b0100, 4'b0000, 3'b000};
        vecs[9] = '{4'b0001, 1, 3'b001, 3, 4'b0001, 4'b0000, 4'b0001, 3'b001};

        for (int vi = 0; vi < 10; vi++) begin
            v = vecs[vi];
            request = v.req;
            wait_grant(ok);
            check($sformatf("v%0d grant_seen", vi), ok, 1);
            check($sformatf("v%0d grant", vi), grant, v.exp_grant);
            check($sformatf("v%0d router", vi), router, v.exp_grant);
            check($sformatf("v%0d busy", vi), busy, 1);

            lcnt = 0;
            while (wr_resetn == 1'b0 && lcnt < 10) begin
                lcnt++;
                tick();
            end
            check($sformatf("v%0d launch_len", vi), lcnt, 2);
            check($sformatf("v%0d run router", vi), router, v.exp_grant);

            rcnt = 0;
            repeat (v.delay) begin
                tick();
                rcnt++;
            end
            e = '{v.exp_grant, v.exp_done, v.exp_err, v.exp_type};
            sb_q.push_back(e);
            wr_type  = v.wtype;
            wr_done  = (v.kind == 0 || v.kind == 2);
            wr_error = (v.kind == 1 || v.kind == 2);
            exp_len  = (v.kind == 3) ? 17 : v.delay + 1;
            do begin
                tick();
                rcnt++;
                wr_done  = 1'b0;
                wr_error = 1'b0;
            end while ((ch_done | ch_err) == 4'd0 && rcnt < 60);
            check($sformatf("v%0d run_len", vi), rcnt, exp_len);
            compare_sb($sformatf("v%0d", vi));

            tick();
            tick();
            check($sformatf("v%0d hold done", vi), ch_done, v.exp_done);
            check($sformatf("v%0d hold error", vi), ch_err, v.exp_err);
            check($sformatf("v%0d hold grant", vi), grant, v.exp_grant);

            request = v.req & ~v.exp_grant;
            tick();
            check($sformatf("v%0d clear grant", vi), grant, 0);
            check($sformatf("v%0d clear flags", vi), ch_done | ch_err, 0);
            check($sformatf("v%0d clear busy", vi), busy, 0);
            check($sformatf("v%0d keep error_type", vi), err_type, v.exp_type);
        end

        // ---- request dropped during LAUNCH: job still completes ----
        request = 4'b0001;
        wait_grant(ok);
        check("drop grant_seen", ok, 1);
        check("drop grant", grant, 4'b0001);
        request = 4'b0000;
        tick();
        tick();
        check("drop run writer_resetn", wr_resetn, 1);
        check("drop run grant", grant, 4'b0001);
        e = '{4'b0001, 4'b0001, 4'b0000, 3'b000};
        sb_q.push_back(e);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        compare_sb("drop");
        tick();
        check("drop clear grant", grant, 0);
        check("drop clear done", ch_done, 0);

        // ---- asynchronous reset mid-RUN ----
        request = 4'b1111;
        wait_grant(ok);
        check("midrun grant", grant, 4'b0010);
        lcnt = 0;
        while (wr_resetn == 1'b0 && lcnt < 10) begin
            lcnt++;
            tick();
        end
        check("midrun in run", wr_resetn, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("async grant", grant, 0);
        check("async router", router, 0);
        check("async busy", busy, 0);
        check("async writer_resetn", wr_resetn, 0);
        check("async flags", ch_done | ch_err, 0);
        check("async error_type", err_type, 0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_grant(ok);
        check("after reset grant_seen", ok, 1);
        check("after reset grant", grant, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
